rsa_ctrl: RTL and testbench
===========================

RSA_CTRL -- requirements
Module: rsa_ctrl

Interface
REQ-001 SHALL have parameter W, default 6: operand width of B/N/C.
REQ-002 SHALL have parameter TMO, default 70: max cycles in MUL before timeout.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request one exponentiation; sampled only in IDLE.
REQ-006 SHALL have port c_in  input  W  exponent presented alongside the B/N/C datapath inputs.
REQ-007 SHALL have port n_in  input  W  modulus presented alongside the datapath inputs.
REQ-008 SHALL have port dp_done  input  1  down-counter done from the datapath.
REQ-009 SHALL have ports load_b, load_n, load_c, load_r  output  1 each  datapath register loads.
REQ-010 SHALL have port s  output  1  multiplier operand select, 0 = B, 1 = fed-back mod.
REQ-011 SHALL have port preset  output  1  datapath counter preset.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port valid  output  1  one-cycle pulse when the datapath result register holds the new result.
REQ-014 SHALL have port err  output  1  one-cycle pulse on a rejected request or timeout.

Function
REQ-015 SHALL be a Moore FSM with states IDLE, LOAD, PRE, SQ, MUL, STORE, FIN, ERR; all outputs decoded from the registered state only.
REQ-016 IDLE: all outputs 0; start=1 with n_in<2 or c_in<2 -> ERR; start=1 otherwise -> LOAD; start=0 -> stay.
REQ-017 LOAD: load_b=load_n=load_c=1 for exactly one cycle -> PRE.
REQ-018 PRE: preset=1 for exactly one cycle -> SQ.
REQ-019 SQ: s=0 for exactly one cycle, so the datapath forms B*B -> MUL; the timeout counter is cleared to 0.
REQ-020 MUL: s=1; each cycle, dp_done=1 -> STORE; else timeout counter +1; when the counter reaches TMO-1 with dp_done=0 -> ERR.
REQ-021 If dp_done=1 in the same cycle the counter reaches TMO-1, dp_done SHALL win and the next state SHALL be STORE.
REQ-022 The timeout counter SHALL be ceil(log2(TMO+1)) bits, saturate rather than wrap, and hold its value outside MUL except when cleared in SQ.
REQ-023 STORE: load_r=1, s=1 for one cycle -> FIN.
REQ-024 FIN: valid=1 for one cycle -> IDLE.
REQ-025 ERR: err=1 for one cycle; no load, preset or load_r asserted -> IDLE.
REQ-026 start SHALL be ignored in every state except IDLE; start held high SHALL launch a new request on the cycle after FIN or ERR returns to IDLE.
REQ-027 dp_done SHALL be ignored in every state except MUL.
REQ-028 At most one of load_b/load_c/load_n (as a group), preset, load_r, valid, err SHALL be high in any cycle.
REQ-029 Minimum request latency, from the start sample to the valid pulse, SHALL be 6 cycles: LOAD, PRE, SQ, one MUL cycle, STORE, FIN.

Reset
REQ-030 rst=0 at a rising edge SHALL force IDLE and clear the timeout counter.
REQ-031 While in IDLE after reset, all outputs SHALL be 0.
REQ-032 Reset SHALL take priority over every transition, including mid-MUL, and SHALL produce no valid or err pulse.
REQ-033 Reset SHALL have no asynchronous effect; outputs change only at clock edges.

Verification
REQ-034 Normal run: n_in=33, c_in=7, start one cycle, dp_done raised on the 4th MUL cycle -> state sequence LOAD, PRE, SQ, MUL x4, STORE, FIN; one valid pulse 9 cycles after start; busy high throughout.
REQ-035 Rejects: start with n_in=1; then start with c_in=0; then start with c_in=1 -> each gives err=1 on the next cycle, with no load or preset asserted.
REQ-036 Timeout: dp_done held 0 -> err pulses after exactly TMO MUL cycles (70); no load_r and no valid.
REQ-037 Boundary: dp_done=1 exactly on MUL cycle 70 -> STORE then valid, with no err.
REQ-038 Reset in MUL (rst=0 one cycle) -> IDLE next edge, all outputs 0, no valid or err; a subsequent start completes normally.
REQ-039 start held high across two requests, with pulses on start mid-run -> mid-run pulses ignored; the second request begins the cycle after FIN returns to IDLE; exactly two valid pulses.

Source files
------------

// File: rtl/rsa_ctrl_if.sv
// Handshake and datapath-control bundle between the RSA controller and its
// requester/datapath; signal names match the controller's documented ports.
interface rsa_ctrl_if #(
  parameter int W = 6
);
  logic         start;
  logic [W-1:0] c_in;
  logic [W-1:0] n_in;
  logic         dp_done;
  logic         load_b;
  logic         load_n;
  logic         load_c;
  logic         load_r;
  logic         s;
  logic         preset;
  logic         busy;
  logic         valid;
  logic         err;

  modport slave (
    input  start, c_in, n_in, dp_done,
    output load_b, load_n, load_c, load_r, s, preset, busy, valid, err
  );

  modport master (
    output start, c_in, n_in, dp_done,
    input  load_b, load_n, load_c, load_r, s, preset, busy, valid, err
  );
endinterface

// File: rtl/rsa_ctrl.sv
// Moore sequencer for a square-and-multiply modular exponentiation datapath,
// with operand rejection and a saturating MUL-phase timeout.
module rsa_ctrl #(
  parameter int W   = 6,
  parameter int TMO = 70
) (
  input  logic       clk,
  input  logic       rst,
  rsa_ctrl_if.slave  bus
);
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TMO);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_SQ    = 3'd3;
  localparam logic [2:0] S_MUL   = 3'd4;
  localparam logic [2:0] S_STORE = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          bad_operands;

  // Exponent or modulus below 2 makes the exponentiation meaningless.
  assign bad_operands = (bus.n_in < W'(2)) || (bus.c_in < W'(2));

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = bad_operands ? S_ERR : S_LOAD;
      end
      S_LOAD:  state_d = S_PRE;
      S_PRE:   state_d = S_SQ;
      S_SQ: begin
        state_d = S_MUL;
        tmo_d   = '0;
      end
      S_MUL: begin
        // Completion beats the timeout when both land on the last cycle.
        if (bus.dp_done) begin
          state_d = S_STORE;
        end else begin
          if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
          if (tmo_q >= TMO_LAST) state_d = S_ERR;
        end
      end
      S_STORE: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.load_b = (state_q == S_LOAD);
  assign bus.load_n = (state_q == S_LOAD);
  assign bus.load_c = (state_q == S_LOAD);
  assign bus.preset = (state_q == S_PRE);
  assign bus.s      = (state_q == S_MUL) || (state_q == S_STORE);
  assign bus.load_r = (state_q == S_STORE);
  assign bus.valid  = (state_q == S_FIN);
  assign bus.err    = (state_q == S_ERR);
  assign bus.busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_rsa_ctrl.sv
// Directed bench for rsa_ctrl: compares the packed output vector every cycle
// against hand-derived per-state patterns.
module tb_rsa_ctrl;
  localparam int W = 6;

  // {load_b, load_n, load_c, load_r, s, preset, busy, valid, err}
  localparam logic [8:0] O_IDLE  = 9'b000_0_0_0_0_0_0;
  localparam logic [8:0] O_LOAD  = 9'b111_0_0_0_1_0_0;
  localparam logic [8:0] O_PRE   = 9'b000_0_0_1_1_0_0;
  localparam logic [8:0] O_SQ    = 9'b000_0_0_0_1_0_0;
  localparam logic [8:0] O_MUL   = 9'b000_0_1_0_1_0_0;
  localparam logic [8:0] O_STORE = 9'b000_1_1_0_1_0_0;
  localparam logic [8:0] O_FIN   = 9'b000_0_0_0_1_1_0;
  localparam logic [8:0] O_ERR   = 9'b000_0_0_0_1_0_1;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rsa_ctrl_if #(.W(W)) bus ();

  rsa_ctrl #(.W(W), .TMO(70)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] outs;
  assign outs = {bus.load_b, bus.load_n, bus.load_c, bus.load_r, bus.s,
                 bus.preset, bus.busy, bus.valid, bus.err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b1;
    bus.n_in = 6'd33;
    bus.c_in = 6'd7;
    bus.dp_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== O_IDLE) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b expected %b", i, outs, O_IDLE);
      end
    end
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dp_done = 1'b0;
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", outs, O_IDLE);
    end
  endtask

  task automatic test_normal();
    logic [8:0] exp;
    int nvalid = 0;
    bus.n_in = 6'd33;
    bus.c_in = 6'd7;
    bus.start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      bus.start = 1'b0;
      case (i)
        1: exp = O_LOAD;
        2: exp = O_PRE;
        3: exp = O_SQ;
        4, 5, 6, 7: exp = O_MUL;
        8: exp = O_STORE;
        9: exp = O_FIN;
        default: exp = O_IDLE;
      endcase
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL normal cyc%0d: got %b expected %b", i, outs, exp);
      end
      if (bus.valid === 1'b1) nvalid++;
      // dp_done outside MUL must be ignored; inside MUL it lands on the 4th cycle
      bus.dp_done = (i <= 3) || (i == 7);
    end
    bus.dp_done = 1'b0;
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("FAIL normal_valid_count: got %0d expected 1", nvalid);
    end
  endtask

  task automatic test_reject();
    int nv[3] = '{1, 33, 33};
    int cv[3] = '{7, 0, 1};
    for (int k = 0; k < 3; k++) begin
      bus.n_in = W'(nv[k]);
      bus.c_in = W'(cv[k]);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (outs !== O_ERR) begin
        errors++;
        $display("FAIL reject%0d_err: got %b expected %b", k, outs, O_ERR);
      end
      tick();
      checks++;
      if (outs !== O_IDLE) begin
        errors++;
        $display("FAIL reject%0d_idle: got %b expected %b", k, outs, O_IDLE);
      end
    end
  endtask

  task automatic test_min_latency();
    logic [8:0] exp;
    bus.n_in = 6'd2;
    bus.c_in = 6'd2;
    bus.dp_done = 1'b1;
    bus.start = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      bus.start = 1'b0;
      case (i)
        1: exp = O_LOAD;
        2: exp = O_PRE;
        3: exp = O_SQ;
        4: exp = O_MUL;
        5: exp = O_STORE;
        6: exp = O_FIN;
        default: exp = O_IDLE;
      endcase
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL minlat cyc%0d: got %b expected %b", i, outs, exp);
      end
    end
    bus.dp_done = 1'b0;
  endtask

  task automatic test_timeout();
    logic [8:0] exp;
    bus.n_in = 6'd33;
    bus.c_in = 6'd7;
    bus.dp_done = 1'b0;
    bus.start = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      tick();
      bus.start = 1'b0;
      if (i == 1) exp = O_LOAD;
      else if (i == 2) exp = O_PRE;
      else if (i == 3) exp = O_SQ;
      else if (i <= 73) exp = O_MUL;
      else if (i == 74) exp = O_ERR;
      else exp = O_IDLE;
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL timeout cyc%0d: got %b expected %b", i, outs, exp);
      end
    end
  endtask

  task automatic test_boundary();
    logic [8:0] exp;
    bus.n_in = 6'd33;
    bus.c_in = 6'd7;
    bus.dp_done = 1'b0;
    bus.start = 1'b1;
    for (int i = 1; i <= 76; i++) begin
      tick();
      bus.start = 1'b0;
      if (i == 1) exp = O_LOAD;
      else if (i == 2) exp = O_PRE;
      else if (i == 3) exp = O_SQ;
      else if (i <= 73) exp = O_MUL;
      else if (i == 74) exp = O_STORE;
      else if (i == 75) exp = O_FIN;
      else exp = O_IDLE;
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL boundary cyc%0d: got %b expected %b", i, outs, exp);
      end
      // i == 73 shows the 70th MUL cycle, the last one before timeout
      bus.dp_done = (i == 73);
    end
    bus.dp_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    bus.n_in = 6'd33;
    bus.c_in = 6'd7;
    bus.start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      bus.start = 1'b0;
      case (i)
        1: exp = O_LOAD;
        2: exp = O_PRE;
        3: exp = O_SQ;
        default: exp = O_MUL;
      endcase
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL rstmid cyc%0d: got %b expected %b", i, outs, exp);
      end
    end
    rst = 1'b0;
    bus.dp_done = 1'b1;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (outs !== O_IDLE) begin
        errors++;
        $display("FAIL rstmid_idle%0d: got %b expected %b", i, outs, O_IDLE);
      end
      tick();
    end
    bus.dp_done = 1'b0;
    test_min_latency();
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int nvalid = 0;
    bus.n_in = 6'd33;
    bus.c_in = 6'd7;
    bus.dp_done = 1'b0;
    bus.start = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      case (i)
        1, 8: exp = O_LOAD;
        2, 9: exp = O_PRE;
        3, 10: exp = O_SQ;
        4, 11: exp = O_MUL;
        5, 12: exp = O_STORE;
        6, 13: exp = O_FIN;
        default: exp = O_IDLE;
      endcase
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL b2b cyc%0d: got %b expected %b", i, outs, exp);
      end
      if (bus.valid === 1'b1) nvalid++;
      bus.dp_done = (i == 4) || (i == 11);
      bus.start = (i < 13) && (i != 2) && (i != 9);
    end
    bus.start = 1'b0;
    bus.dp_done = 1'b0;
    checks++;
    if (nvalid != 2) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d expected 2", nvalid);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.n_in = '0;
    bus.c_in = '0;
    bus.dp_done = 1'b0;
    test_reset();
    test_normal();
    test_reject();
    test_min_latency();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
